dcache_wt: RTL and testbench

//  Direct-mapped, write-through, write-allocate cache between the cpu core's 16-bit

---
 rtl/cache_pkg.sv | 36 +++
 rtl/cache_line_array.sv | 44 ++++
 rtl/dcache_wt.sv | 162 ++++++++++++++++
 tb/tb_dcache_wt.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared cache geometry, FSM state encoding and line/address helpers.
package cache_pkg;
  localparam int LINE_WORDS = 4;
  localparam int WORD_SIZE  = 16;
  localparam int LINE_SIZE  = LINE_WORDS * WORD_SIZE;
  localparam int ADDR_W     = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2
  } cache_state_e;

  function automatic logic [1:0] addr_offset(input logic [ADDR_W-1:0] addr);
    return addr[1:0];
  endfunction

  // Line number = word address with the in-line offset dropped.
  function automatic logic [ADDR_W-3:0] addr_line(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:2];
  endfunction

  function automatic logic [WORD_SIZE-1:0] line_word(input logic [LINE_SIZE-1:0] line,
                                                     input logic [1:0] off);
    return line[off*WORD_SIZE +: WORD_SIZE];
  endfunction

  function automatic logic [LINE_SIZE-1:0] merge_word(input logic [LINE_SIZE-1:0] line,
                                                      input logic [1:0] off,
                                                      input logic [WORD_SIZE-1:0] wdata);
    logic [LINE_SIZE-1:0] merged;
    merged = line;
    merged[off*WORD_SIZE +: WORD_SIZE] = wdata;
    return merged;
  endfunction
endpackage

// File: rtl/cache_line_array.sv
// Valid/tag/data storage: one combinational read port, one synchronous write port.
module cache_line_array
  import cache_pkg::*;
#(
  parameter int INDEX_BITS = 3,
  parameter int TAG_BITS   = 11
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [INDEX_BITS-1:0] rd_index_i,
  output logic                  rd_valid_o,
  output logic [TAG_BITS-1:0]   rd_tag_o,
  output logic [LINE_SIZE-1:0]  rd_line_o,
  input  logic                  we_i,
  input  logic [INDEX_BITS-1:0] wr_index_i,
  input  logic [TAG_BITS-1:0]   wr_tag_i,
  input  logic [LINE_SIZE-1:0]  wr_line_i
);
  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]     valid_q;
  logic [TAG_BITS-1:0]  tag_q  [LINES];
  logic [LINE_SIZE-1:0] data_q [LINES];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_index_i] <= 1'b1;
    end
  end

  // Tag and data are deliberately left unreset; valid gates every use.
  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_q[wr_index_i]  <= wr_tag_i;
      data_q[wr_index_i] <= wr_line_i;
    end
  end

  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_line_o  = data_q[rd_index_i];
endmodule

// File: rtl/dcache_wt.sv
// Direct-mapped write-through, write-allocate cache: 16-bit core port, 64-bit line memory port.
module dcache_wt
  import cache_pkg::*;
#(
  parameter int MEM_LATENCY = 4,
  parameter int INDEX_BITS  = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cpu_req_read_i,
  input  logic                 cpu_req_write_i,
  input  logic [ADDR_W-1:0]    cpu_addr_i,
  input  logic [WORD_SIZE-1:0] cpu_wdata_i,
  output logic [WORD_SIZE-1:0] cpu_rdata_o,
  output logic                 cpu_stall_o,
  output logic                 mem_read_o,
  output logic                 mem_write_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic [LINE_SIZE-1:0] mem_wdata_o,
  input  logic [LINE_SIZE-1:0] mem_rdata_i,
  output logic [15:0]          stat_access_o,
  output logic [15:0]          stat_hit_o
);
  localparam int TAG_BITS = ADDR_W - INDEX_BITS - 2;
  localparam int CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

  cache_state_e          state_q, state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [ADDR_W-3:0]     line_q;
  logic [LINE_SIZE-1:0]  wdata_q;
  logic [15:0]           stat_access_q, stat_hit_q;
  logic                  filled_q;
  logic                  wdone_q;

  logic [1:0]            offset;
  logic [ADDR_W-3:0]     cpu_line;
  logic                  rd_valid, hit, req, req_wr, req_rd, last;
  logic [TAG_BITS-1:0]   rd_tag;
  logic [LINE_SIZE-1:0]  rd_line, merged_line, arr_wr_line;
  logic                  arr_we;

  assign offset   = addr_offset(cpu_addr_i);
  assign cpu_line = addr_line(cpu_addr_i);
  // A simultaneous read+write is served as a write.
  assign req_wr   = cpu_req_write_i;
  assign req_rd   = cpu_req_read_i & ~cpu_req_write_i;
  assign req      = req_rd | req_wr;
  assign hit      = rd_valid && (rd_tag == cpu_line[ADDR_W-3:INDEX_BITS]);
  assign last     = (cnt_q == CNT_LAST);
  assign merged_line = merge_word(rd_line, offset, cpu_wdata_i);

  assign arr_we      = reset_n && last && (state_q == ST_FILL || state_q == ST_WRITE);
  assign arr_wr_line = (state_q == ST_FILL) ? mem_rdata_i : wdata_q;

  cache_line_array #(
    .INDEX_BITS(INDEX_BITS),
    .TAG_BITS  (TAG_BITS)
  ) u_array (
    .clk       (clk),
    .reset_n   (reset_n),
    .rd_index_i(cpu_line[INDEX_BITS-1:0]),
    .rd_valid_o(rd_valid),
    .rd_tag_o  (rd_tag),
    .rd_line_o (rd_line),
    .we_i      (arr_we),
    .wr_index_i(line_q[INDEX_BITS-1:0]),
    .wr_tag_i  (line_q[ADDR_W-3:INDEX_BITS]),
    .wr_line_i (arr_wr_line)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req && !wdone_q) begin
          if (!hit)        state_d = ST_FILL;
          else if (req_wr) state_d = ST_WRITE;
        end
      end
      ST_FILL:  if (last) state_d = ST_IDLE;
      ST_WRITE: if (last) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cpu_stall_o = 1'b0;
    mem_read_o  = 1'b0;
    mem_write_o = 1'b0;
    cpu_rdata_o = '0;
    if (reset_n) cpu_rdata_o = line_word(rd_line, offset);
    case (state_q)
      ST_IDLE:  cpu_stall_o = reset_n && req && !wdone_q && (req_wr || !hit);
      ST_FILL: begin
        mem_read_o  = 1'b1;
        cpu_stall_o = reset_n;
      end
      ST_WRITE: begin
        mem_write_o = 1'b1;
        cpu_stall_o = reset_n;
      end
      default: ;
    endcase
  end

  // filled_q marks a request whose line was just allocated, so it is not counted as a hit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q         <= '0;
      line_q        <= '0;
      wdata_q       <= '0;
      stat_access_q <= '0;
      stat_hit_q    <= '0;
      filled_q      <= 1'b0;
      wdone_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_q   <= '0;
          wdone_q <= 1'b0;
          if (req && !wdone_q) begin
            if (!hit) begin
              line_q <= cpu_line;
            end else if (req_wr) begin
              line_q  <= cpu_line;
              wdata_q <= merged_line;
            end else begin
              stat_access_q <= stat_access_q + 16'd1;
              if (!filled_q) stat_hit_q <= stat_hit_q + 16'd1;
              filled_q <= 1'b0;
            end
          end
        end
        ST_FILL: begin
          cnt_q <= last ? '0 : cnt_q + CNT_W'(1);
          if (last) filled_q <= 1'b1;
        end
        ST_WRITE: begin
          cnt_q <= last ? '0 : cnt_q + CNT_W'(1);
          if (last) begin
            stat_access_q <= stat_access_q + 16'd1;
            if (!filled_q) stat_hit_q <= stat_hit_q + 16'd1;
            filled_q <= 1'b0;
            wdone_q  <= 1'b1;
          end
        end
        default: cnt_q <= '0;
      endcase
    end
  end

  assign mem_addr_o    = {line_q, 2'b00};
  assign mem_wdata_o   = wdata_q;
  assign stat_access_o = stat_access_q;
  assign stat_hit_o    = stat_hit_q;
endmodule

// File: tb/tb_dcache_wt.sv
// Directed bench for dcache_wt: fills, hits, conflicts, write hit/miss and reset mid-fill.
module tb_dcache_wt;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_req_read, cpu_req_write;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall, mem_read, mem_write;
  logic [15:0] mem_addr;
  logic [63:0] mem_wdata, mem_rdata;
  logic [15:0] stat_access, stat_hit;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Memory model: word k of the line at base A is (A+k) ^ 16'h0A1A.
  function automatic logic [63:0] mem_line(input logic [15:0] base);
    logic [63:0] l;
    for (int k = 0; k < 4; k++) l[16*k +: 16] = (base + 16'(k)) ^ 16'h0A1A;
    return l;
  endfunction
  assign mem_rdata = mem_line(mem_addr);

  dcache_wt #(.MEM_LATENCY(4), .INDEX_BITS(3)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cpu_req_read_i (cpu_req_read),
    .cpu_req_write_i(cpu_req_write),
    .cpu_addr_i     (cpu_addr),
    .cpu_wdata_i    (cpu_wdata),
    .cpu_rdata_o    (cpu_rdata),
    .cpu_stall_o    (cpu_stall),
    .mem_read_o     (mem_read),
    .mem_write_o    (mem_write),
    .mem_addr_o     (mem_addr),
    .mem_wdata_o    (mem_wdata),
    .mem_rdata_i    (mem_rdata),
    .stat_access_o  (stat_access),
    .stat_hit_o     (stat_hit)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request (called at posedge+1) and follow it until stall drops.
  int          n_stall, n_rd, n_wr, n_ovl, n_unstable;
  logic [15:0] got_rdata, seen_addr;
  logic [63:0] seen_wdata;
  task automatic do_req(input logic rd, input logic wr, input logic [15:0] addr,
                        input logic [15:0] wdata);
    bit done = 0;
    bit have_addr = 0;
    n_stall = 0; n_rd = 0; n_wr = 0; n_ovl = 0; n_unstable = 0;
    got_rdata = '0; seen_addr = '0; seen_wdata = '0;
    cpu_req_read = rd; cpu_req_write = wr; cpu_addr = addr; cpu_wdata = wdata;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (mem_read)  n_rd++;
      if (mem_write) begin n_wr++; seen_wdata = mem_wdata; end
      if (mem_read && mem_write) n_ovl++;
      if (mem_read || mem_write) begin
        if (have_addr && mem_addr !== seen_addr) n_unstable++;
        seen_addr = mem_addr;
        have_addr = 1;
      end
      if (!cpu_stall) begin
        got_rdata = cpu_rdata;
        done = 1;
      end else begin
        n_stall++;
      end
      @(posedge clk); #1;
    end
    cpu_req_read = 0; cpu_req_write = 0;
    chk("req_completed", 64'(done), 64'd1);
  endtask

  initial begin
    reset_n = 0; cpu_req_read = 0; cpu_req_write = 0; cpu_addr = '0; cpu_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 64'(cpu_stall), 64'd0);
    chk("rst_rdata", 64'(cpu_rdata), 64'd0);
    chk("rst_strobes", 64'({mem_read, mem_write}), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", mem_wdata, 64'd0);
    chk("rst_stats", 64'({stat_access, stat_hit}), 64'd0);
    @(posedge clk); #1;
    reset_n = 1;

    // Cold read miss
    do_req(1, 0, 16'h0010, 16'h0);
    chk("cold_stall", 64'(n_stall), 64'd5);
    chk("cold_rd_cycles", 64'(n_rd), 64'd4);
    chk("cold_fill_addr", 64'(seen_addr), 64'h0010);
    chk("cold_rdata", 64'(got_rdata), 64'h0A0A);
    chk("cold_stats", 64'({stat_access, stat_hit}), 64'h0001_0000);

    // Hit in the same line
    do_req(1, 0, 16'h0011, 16'h0);
    chk("hit_stall", 64'(n_stall), 64'd0);
    chk("hit_no_memrd", 64'(n_rd), 64'd0);
    chk("hit_rdata", 64'(got_rdata), 64'h0A0B);
    chk("hit_stats", 64'({stat_access, stat_hit}), 64'h0002_0001);

    // Conflict on index 4
    do_req(1, 0, 16'h0030, 16'h0);
    chk("conf1_stall", 64'(n_stall), 64'd5);
    chk("conf1_rdata", 64'(got_rdata), 64'h0A2A);
    do_req(1, 0, 16'h0010, 16'h0);
    chk("conf2_rd_cycles", 64'(n_rd), 64'd4);
    chk("conf2_rdata", 64'(got_rdata), 64'h0A0A);
    chk("conf_stats", 64'({stat_access, stat_hit}), 64'h0004_0001);

    // Write hit
    do_req(0, 1, 16'h0012, 16'hBEEF);
    chk("wh_stall", 64'(n_stall), 64'd5);
    chk("wh_wr_cycles", 64'(n_wr), 64'd4);
    chk("wh_rd_cycles", 64'(n_rd), 64'd0);
    chk("wh_mem_addr", 64'(seen_addr), 64'h0010);
    chk("wh_mem_wdata", seen_wdata, 64'h0A09_BEEF_0A0B_0A0A);
    chk("wh_addr_stable", 64'(n_unstable), 64'd0);
    chk("wh_stats", 64'({stat_access, stat_hit}), 64'h0005_0002);
    do_req(1, 0, 16'h0012, 16'h0);
    chk("wh_readback_stall", 64'(n_stall), 64'd0);
    chk("wh_readback", 64'(got_rdata), 64'hBEEF);

    // Write miss: allocate then write through
    do_req(0, 1, 16'h0101, 16'h1234);
    chk("wm_stall", 64'(n_stall), 64'd10);
    chk("wm_rd_cycles", 64'(n_rd), 64'd4);
    chk("wm_wr_cycles", 64'(n_wr), 64'd4);
    chk("wm_overlap", 64'(n_ovl), 64'd0);
    chk("wm_mem_addr", 64'(seen_addr), 64'h0100);
    chk("wm_mem_wdata", seen_wdata, 64'h0B19_0B18_1234_0B1A);
    chk("wm_stats", 64'({stat_access, stat_hit}), 64'h0007_0003);
    do_req(1, 0, 16'h0101, 16'h0);
    chk("wm_readback", 64'(got_rdata), 64'h1234);
    chk("wm_readback_stall", 64'(n_stall), 64'd0);

    // Read and write together act as a write
    do_req(1, 1, 16'h0103, 16'h5555);
    chk("rw_stall", 64'(n_stall), 64'd5);
    chk("rw_wr_cycles", 64'(n_wr), 64'd4);
    chk("rw_mem_wdata", seen_wdata, 64'h5555_0B18_1234_0B1A);

    // Reset during FILL cycle 2
    cpu_req_read = 1; cpu_addr = 16'h0200;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("pre_rst_in_fill", 64'({mem_read, cpu_stall}), 64'b11);
    @(posedge clk); #1;
    reset_n = 0;
    @(negedge clk);
    chk("mid_rst_stall", 64'(cpu_stall), 64'd0);
    chk("mid_rst_rdata", 64'(cpu_rdata), 64'd0);
    @(negedge clk);
    chk("mid_rst_strobes", 64'({mem_read, mem_write}), 64'd0);
    chk("mid_rst_stats", 64'({stat_access, stat_hit}), 64'd0);
    @(posedge clk); #1;
    cpu_req_read = 0;
    reset_n = 1;
    do_req(1, 0, 16'h0200, 16'h0);
    chk("post_rst_miss", 64'(n_stall), 64'd5);
    chk("post_rst_rdata", 64'(got_rdata), 64'h081A);
    do_req(1, 0, 16'h0011, 16'h0);
    chk("post_rst_old_miss", 64'(n_rd), 64'd4);
    chk("post_rst_stats", 64'({stat_access, stat_hit}), 64'h0002_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
